// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled asynchronous serial receiver with optional parity,
// stop-bit checking and a one-entry valid/ready holding register on the output.
module uart_rx_frame #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD    = 1'(PARITY_MODE == 2);
    localparam logic          HAS_P  = 1'(PARITY_MODE != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic                   rx_m;
    logic                   rx_s;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bidx;
    logic                   scnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   perr;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM, shift register, holding register and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            bidx       <= '0;
            scnt       <= 1'b0;
            shreg      <= '0;
            perr       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // Consumer handshake; a completion load later in this block wins.
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (!en) begin
                state <= S_IDLE;
                tcnt  <= '0;
            end else if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state <= S_START;
                            tcnt  <= '0;
                        end
                    end
                    S_START: begin
                        if (tcnt == T_MID) begin
                            tcnt  <= '0;
                            bidx  <= '0;
                            perr  <= 1'b0;
                            state <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tcnt == T_END) begin
                            tcnt  <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            bidx  <= bidx + BW'(1);
                            if (bidx == B_LAST) begin
                                scnt  <= 1'b0;
                                state <= HAS_P ? S_PARITY : S_STOP;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (tcnt == T_END) begin
                            tcnt  <= '0;
                            perr  <= (^shreg) ^ rx_s ^ ODD;
                            state <= S_STOP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_STOP: begin
                        if (tcnt == T_END) begin
                            tcnt <= '0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end else if (scnt == S_LAST) begin
                                state <= S_IDLE;
                                if (!dout_valid || dout_ready) begin
                                    dout       <= shreg;
                                    parity_err <= perr;
                                    dout_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                scnt <= scnt + 1'b1;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives three receiver configurations with directed and
// random frames and compares them with a frame-level reference model.
module tb_uart_rx_frame;

    localparam int TDIV = 4;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       en;
    logic [2:0] rx;
    logic [2:0] rdy;
    logic [2:0] val;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] ovr;
    logic [7:0] dout_a;
    logic [7:0] dout_b;
    logic [6:0] dout_c;
    logic [8:0] dw [3];

    int nb [3] = '{8, 8, 7};
    int os [3] = '{16, 16, 8};
    int pm [3] = '{0, 1, 2};
    int ns [3] = '{1, 2, 1};

    logic [8:0] m_dout [3];
    bit         m_val  [3];
    bit         m_perr [3];

    int fe_cnt [3];
    int ov_cnt [3];
    int both_cnt;
    int n_chk;
    int n_err;
    int tc;

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .rx(rx[0]),
        .dout(dout_a), .dout_valid(val[0]), .dout_ready(rdy[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0])
    );

    uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .rx(rx[1]),
        .dout(dout_b), .dout_valid(val[1]), .dout_ready(rdy[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1])
    );

    uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .rx(rx[2]),
        .dout(dout_c), .dout_valid(val[2]), .dout_ready(rdy[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2])
    );

    always_comb begin
        dw[0] = {1'b0, dout_a};
        dw[1] = {1'b0, dout_b};
        dw[2] = {2'b0, dout_c};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick: one clock high out of every TDIV.
    initial begin
        tick = 1'b0;
        tc   = 0;
        forever begin
            @(negedge clk);
            tick = (tc == 0);
            tc   = (tc + 1) % TDIV;
        end
    end

    // Count high cycles of the status pulses and any overlap between them.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ferr[i] === 1'b1) fe_cnt[i]++;
            if (ovr[i] === 1'b1) ov_cnt[i]++;
            if (ferr[i] === 1'b1 && ovr[i] === 1'b1) both_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input int i, input string tag);
        chk($sformatf("%s_u%0d_valid", tag, i), 32'(val[i]), 32'(m_val[i]));
        chk($sformatf("%s_u%0d_dout", tag, i), 32'(dw[i]), 32'(m_dout[i]));
        chk($sformatf("%s_u%0d_perr", tag, i), 32'(perr[i]), 32'(m_perr[i]));
    endtask

    task automatic chk_zero(input string tag);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s_u%0d_outs", tag, j),
                32'({dw[j], val[j], perr[j], ferr[j], ovr[j]}), 32'(0));
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_dout[j] = '0;
            m_val[j]  = 1'b0;
            m_perr[j] = 1'b0;
        end
    endtask

    task automatic ready_pulse(input int i);
        @(negedge clk);
        rdy[i] = 1'b1;
        @(negedge clk);
        rdy[i] = 1'b0;
        m_val[i] = 1'b0;
    endtask

    // Send one frame on receiver i; optional bad stop bit, trailing low time,
    // abort (0 = reset, 1 = enable drop) at a data bit, ready held during stop.
    task automatic send_frame(input int i, input logic [8:0] data, input bit flip,
                              input int bad_stop, input int tail_low,
                              input int abort_at, input int abort_kind,
                              input bit rdy_stop, input string tag);
        int         bp;
        logic [8:0] d;
        bit         x;
        bit         p;
        bit         err;
        bit         exp_fe;
        bit         exp_ov;
        bit         bits[$];
        int         fe0;
        int         ov0;
        bp  = os[i] * TDIV;
        d   = data & 9'((1 << nb[i]) - 1);
        x   = ^d;
        p   = ((pm[i] == 2) ? ~x : x) ^ flip;
        bits.push_back(1'b0);
        for (int k = 0; k < nb[i]; k++) bits.push_back(d[k]);
        if (pm[i] != 0) bits.push_back(p);
        for (int s = 0; s < ns[i]; s++) bits.push_back(s != bad_stop);
        fe0 = fe_cnt[i];
        ov0 = ov_cnt[i];
        for (int k = 0; k < bits.size(); k++) begin
            rx[i] = bits[k];
            if (abort_at >= 0 && k == abort_at + 1) begin
                repeat (bp / 2) @(negedge clk);
                if (abort_kind == 0) begin
                    rst   = 1'b1;
                    rx[i] = 1'b1;
                    #1;
                    chk_zero({tag, "_in_rst"});
                    @(negedge clk);
                    rst = 1'b0;
                    model_reset();
                    #1;
                    chk_zero({tag, "_post_rst"});
                    fe0 = fe_cnt[i];
                    ov0 = ov_cnt[i];
                end else begin
                    en    = 1'b0;
                    rx[i] = 1'b1;
                    repeat (3) @(negedge clk);
                    en = 1'b1;
                end
                repeat (2 * bp) @(negedge clk);
                chk({tag, "_ferr"}, 32'(fe_cnt[i] - fe0), 32'(0));
                chk({tag, "_ovr"}, 32'(ov_cnt[i] - ov0), 32'(0));
                chk_out(i, tag);
                return;
            end
            if (rdy_stop && k == bits.size() - 1) begin
                rdy[i] = 1'b1;
                for (int c = 0; c < bp; c++) begin
                    @(negedge clk);
                    if (rdy[i] && dw[i] == d) rdy[i] = 1'b0;
                end
                rdy[i] = 1'b0;
            end else begin
                repeat (bp) @(negedge clk);
            end
        end
        if (tail_low > 0) begin
            rx[i] = 1'b0;
            repeat (tail_low * bp) @(negedge clk);
        end
        rx[i] = 1'b1;
        repeat (2 * bp) @(negedge clk);
        // Frame-level expectation.
        err    = (pm[i] == 1) ? (x ^ p) : (pm[i] == 2) ? ~(x ^ p) : 1'b0;
        exp_fe = (bad_stop >= 0 && bad_stop < ns[i]);
        exp_ov = 1'b0;
        if (!exp_fe) begin
            if (rdy_stop) m_val[i] = 1'b0;
            if (m_val[i]) begin
                exp_ov = 1'b1;
            end else begin
                m_dout[i] = d;
                m_perr[i] = err;
                m_val[i]  = 1'b1;
            end
        end
        chk({tag, "_ferr"}, 32'(fe_cnt[i] - fe0), 32'(exp_fe));
        chk({tag, "_ovr"}, 32'(ov_cnt[i] - ov0), 32'(exp_ov));
        chk_out(i, tag);
    endtask

    initial begin
        int fe0;
        int ov0;
        rst = 1'b1;
        en  = 1'b1;
        rx  = 3'b111;
        rdy = 3'b000;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(0, 9'hA5, 1'b0, -1, 0, -1, 0, 1'b0, "a5");
        ready_pulse(0);
        @(negedge clk);
        chk_out(0, "a5_consumed");

        send_frame(1, 9'h03, 1'b1, -1, 0, -1, 0, 1'b0, "even_bad");
        ready_pulse(1);
        send_frame(1, 9'h03, 1'b0, -1, 0, -1, 0, 1'b0, "even_good");
        ready_pulse(1);
        send_frame(2, 9'h03, 1'b0, -1, 0, -1, 0, 1'b0, "odd_good");
        ready_pulse(2);

        send_frame(0, 9'h5A, 1'b0, 0, 3, -1, 0, 1'b0, "stop0");
        send_frame(0, 9'h11, 1'b0, -1, 0, -1, 0, 1'b0, "after_break");

        send_frame(0, 9'h22, 1'b0, -1, 0, -1, 0, 1'b0, "overrun");
        ready_pulse(0);
        send_frame(0, 9'h11, 1'b0, -1, 0, -1, 0, 1'b0, "hold11");
        send_frame(0, 9'h22, 1'b0, -1, 0, -1, 0, 1'b1, "ready_at_done");
        ready_pulse(0);

        fe0 = fe_cnt[0];
        ov0 = ov_cnt[0];
        rx[0] = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * os[0] * TDIV) @(negedge clk);
        chk("glitch_ferr", 32'(fe_cnt[0] - fe0), 32'(0));
        chk("glitch_ovr", 32'(ov_cnt[0] - ov0), 32'(0));
        chk_out(0, "glitch");
        send_frame(0, 9'h3C, 1'b0, -1, 0, -1, 0, 1'b0, "post_glitch");
        ready_pulse(0);

        send_frame(0, 9'h77, 1'b0, -1, 0, 3, 0, 1'b0, "rst_abort");
        send_frame(0, 9'h3C, 1'b0, -1, 0, -1, 0, 1'b0, "post_rst");
        ready_pulse(0);
        send_frame(0, 9'h77, 1'b0, -1, 0, 4, 1, 1'b0, "en_abort");
        send_frame(0, 9'h3C, 1'b0, -1, 0, -1, 0, 1'b0, "post_en");

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) begin
                logic [8:0] d;
                bit         fl;
                int         bs;
                d  = 9'($urandom);
                fl = ($urandom_range(3) == 0);
                bs = ($urandom_range(5) == 0) ? int'($urandom_range(ns[i] - 1)) : -1;
                send_frame(i, d, fl, bs, 0, -1, 0, 1'b0, $sformatf("rnd%0d", n));
                if ($urandom_range(1) == 1) begin
                    ready_pulse(i);
                    @(negedge clk);
                    chk_out(i, $sformatf("rnd%0d_rdy", n));
                end
            end
        end

        chk("no_overlap", 32'(both_cnt), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised successor to the tick-driven serial deserializer. It receives asynchronous serial frames on rx using an oversampling enable tick, samples mid-bit and shifts data LSB-first. It checks optional parity and the stop bit(s), then presents each completed word through a one-entry valid/ready holding register. It sits between the XBee UART pin and the byte-consuming logic on the Nexys2.

Parameters:
DATA_BITS, 8, data bits per frame (5..9); dout width.
OVERSAMPLE, 16, tick pulses per bit period (even, 4..32).
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits checked (1 or 2).

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
tick  in  1  oversample enable; 1-clk pulse, OVERSAMPLE per bit period.
en  in  1  receiver enable; low forces IDLE.
rx  in  1  serial input, idle high; asynchronous to clk.
dout  out  DATA_BITS  received word, LSB = first data bit.
dout_valid  out  1  holding register full.
dout_ready  in  1  consumer accepts dout on clk edge when dout_valid=1.
parity_err  out  1  parity status of held word; valid while dout_valid=1.
frame_err  out  1  1-clk pulse: stop bit sampled 0.
overrun  out  1  1-clk pulse: completed word dropped because holding register full.

Behaviour:
- One clock and one reset: a single clock, clk; rst is asynchronous and active-high.
- Reset: state IDLE, all counters 0. dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0. The rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, evaluated only on clk edges where tick=1.
- Tick counter tcnt, width clog2(OVERSAMPLE).
- States:
  - IDLE: on tick with rx_s=0, go to START with tcnt=0.
  - START: at tcnt=OVERSAMPLE/2-1, re-sample. If rx_s=0, go to DATA with tcnt=0 and bit index 0. If rx_s=1, treat as a glitch and return to IDLE with no flags.
  - DATA: at tcnt=OVERSAMPLE-1, sample rx_s into shift register, MSB-in/right shift, so the first bit ends at bit 0. After DATA_BITS samples go to PARITY (PARITY_MODE≠0) or STOP.
  - PARITY: at tcnt=OVERSAMPLE-1, sample p. Error when the XOR of data bits and p ≠ 0 (even mode), or ≠ 1 (odd mode).
  - STOP: at tcnt=OVERSAMPLE-1, sample. Any stop sample of 0 pulses frame_err, discards the word and enters BREAK. After STOP_BITS good samples, the frame completes and the state returns to IDLE.
  - BREAK: wait for a tick with rx_s=1, then go to IDLE.
- Completion, on the clk edge after the final stop sample:
  - Holding register empty, or (dout_valid & dout_ready) on the same edge: load dout and parity_err, dout_valid=1.
  - Otherwise: held word kept unchanged, overrun pulses for 1 clk, new word dropped.
- dout_valid clears on an edge with dout_ready=1 unless a new load occurs on that edge. dout and parity_err hold their value until the next load.
- en=0: the FSM enters IDLE on the next edge and discards any partial frame without flags. The holding register and handshake are unaffected.
- rst mid-frame: immediate return to reset values; a pending held word is lost.
- frame_err and overrun are never asserted together and never asserted for more than 1 clk per frame.

Test Plan:
- Default params, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with dout_ready=0 → dout=0xA5, dout_valid=1, parity_err=0. Pulse dout_ready 1 clk → dout_valid=0, dout still 0xA5.
- PARITY_MODE=1, send 0x03 with parity bit 1 → dout=0x03, parity_err=1. Resend with parity bit 0 → parity_err=0. PARITY_MODE=2, 0x03 with parity bit 1 → parity_err=0.
- Send 0x5A with stop bit 0 → frame_err 1-clk pulse, dout_valid stays 0. Hold rx low 3 bit times then high, send 0x11 → dout=0x11.
- Send 0x11 then 0x22 with dout_ready=0 → dout=0x11, overrun pulse at end of the second frame. Repeat with dout_ready=1 on the completion edge → dout=0x22, no overrun.
- rx low for 4 ticks then high (OVERSAMPLE=16) → no state beyond START, no flags, dout_valid=0.
- Assert rst for 1 clk mid-DATA of frame 0x77 → all outputs 0 during and after reset. The next full frame 0x3C is received correctly. Repeat with en=0 mid-frame → no output for the partial frame, next frame correct.
